// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised IEEE-754 style adder/subtractor.
// Operand capture, unpack/swap, align/sum, normalise/round/pack.
module fp_addsub_pipe #(
    parameter int  EXP_BITS  = 8,
    parameter int  FRAC_BITS = 23,
    localparam int W         = 1 + EXP_BITS + FRAC_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    localparam int E   = EXP_BITS;
    localparam int F   = FRAC_BITS;
    localparam int SW  = F + 5;
    localparam int LZW = $clog2(F + 5);
    localparam int NW  = ((E > LZW) ? E : LZW) + 2;

    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic [NW-1:0] EXP_MAX = {{(NW-E){1'b0}}, {E{1'b1}}};

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    typedef struct packed {
        logic         spec;
        logic [W-1:0] spec_res;
        logic         sign;
        logic         add_op;
        logic [E-1:0] exp;
        logic [F:0]   big_sig;
        logic [F:0]   sml_sig;
        logic [E-1:0] d;
    } s1_t;

    typedef struct packed {
        logic          spec;
        logic [W-1:0]  spec_res;
        logic          sign;
        logic          add_op;
        logic [E-1:0]  exp;
        logic [SW-1:0] sum;
    } s2_t;

    function automatic logic [LZW-1:0] lzc(input logic [F+3:0] v);
        lzc = LZW'(F + 4);
        for (int i = 0; i <= F + 3; i++) begin
            if (v[i]) lzc = LZW'(F + 3 - i);
        end
    endfunction

    logic         stall;
    logic         v0, v1, v2, v3;
    op_t          op_q;
    s1_t          s1_n, s1_q;
    s2_t          s2_n, s2_q;
    logic [W-1:0] res_n, res_q;

    assign stall     = v3 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3;
    assign result    = res_q;

    // S1: classify, effective signs, magnitude swap
    logic         a_s, b_s;
    logic [E-1:0] a_e, b_e, a_ee, b_ee;
    logic [F-1:0] a_f, b_f;
    logic         a_nan, b_nan, a_inf, b_inf, swap;

    always_comb begin
        a_s   = op_q.a[W-1];
        a_e   = op_q.a[W-2:F];
        a_f   = op_q.a[F-1:0];
        b_s   = op_q.b[W-1] ^ op_q.sub;
        b_e   = op_q.b[W-2:F];
        b_f   = op_q.b[F-1:0];
        a_nan = (a_e == '1) && (a_f != '0);
        b_nan = (b_e == '1) && (b_f != '0);
        a_inf = (a_e == '1) && (a_f == '0);
        b_inf = (b_e == '1) && (b_f == '0);
        a_ee  = (a_e == '0) ? E'(1) : a_e;
        b_ee  = (b_e == '0) ? E'(1) : b_e;
        swap  = op_q.b[W-2:0] > op_q.a[W-2:0];

        s1_n        = '0;
        s1_n.add_op = (a_s == b_s);
        if (a_nan || b_nan || (a_inf && b_inf && !s1_n.add_op)) begin
            s1_n.spec     = 1'b1;
            s1_n.spec_res = QNAN;
        end else if (a_inf) begin
            s1_n.spec     = 1'b1;
            s1_n.spec_res = {a_s, a_e, a_f};
        end else if (b_inf) begin
            s1_n.spec     = 1'b1;
            s1_n.spec_res = {b_s, b_e, b_f};
        end

        if (swap) begin
            s1_n.sign    = b_s;
            s1_n.exp     = b_ee;
            s1_n.big_sig = {(b_e != '0), b_f};
            s1_n.sml_sig = {(a_e != '0), a_f};
            s1_n.d       = b_ee - a_ee;
        end else begin
            s1_n.sign    = a_s;
            s1_n.exp     = a_ee;
            s1_n.big_sig = {(a_e != '0), a_f};
            s1_n.sml_sig = {(b_e != '0), b_f};
            s1_n.d       = a_ee - b_ee;
        end
    end

    // S2: align small operand with guard/round/sticky, then sum
    logic [F+3:0]  ext, shf, mask, aligned;
    logic          lost;
    logic [SW-1:0] big_x, sml_x;

    always_comb begin
        ext  = {s1_q.sml_sig, 3'b000};
        mask = ~({(F+4){1'b1}} << s1_q.d);
        shf  = ext >> s1_q.d;
        lost = |(ext & mask);
        if (int'(s1_q.d) >= F + 3) begin
            aligned = {{(F+3){1'b0}}, |ext};
        end else begin
            aligned = {shf[F+3:1], shf[0] | lost};
        end
        big_x = {1'b0, s1_q.big_sig, 3'b000};
        sml_x = {1'b0, aligned};

        s2_n          = '0;
        s2_n.spec     = s1_q.spec;
        s2_n.spec_res = s1_q.spec_res;
        s2_n.sign     = s1_q.sign;
        s2_n.add_op   = s1_q.add_op;
        s2_n.exp      = s1_q.exp;
        s2_n.sum      = s1_q.add_op ? big_x + sml_x : big_x - sml_x;
    end

    // S3: normalise, round to nearest even, pack
    logic [F+3:0]  norm;
    logic [NW-1:0] ex, lz, sh;
    logic [F+1:0]  rnd;
    logic          up;

    always_comb begin
        ex   = NW'(s2_q.exp);
        lz   = '0;
        sh   = '0;
        norm = '0;
        if (s2_q.sum[F+4]) begin
            norm = {s2_q.sum[F+4:2], |s2_q.sum[1:0]};
            ex   = ex + NW'(1);
        end else begin
            lz   = NW'(lzc(s2_q.sum[F+3:0]));
            // never normalise below the minimum exponent
            sh   = (lz < ex - NW'(1)) ? lz : ex - NW'(1);
            norm = s2_q.sum[F+3:0] << sh;
            ex   = ex - sh;
        end

        up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[F+3:3]} + (F+2)'(up);
        if (rnd[F+1]) begin
            rnd = rnd >> 1;
            ex  = ex + NW'(1);
        end

        if (s2_q.spec) begin
            res_n = s2_q.spec_res;
        end else if (s2_q.sum == '0) begin
            res_n = {s2_q.add_op & s2_q.sign, {(W-1){1'b0}}};
        end else if (ex >= EXP_MAX) begin
            res_n = {s2_q.sign, {E{1'b1}}, {F{1'b0}}};
        end else begin
            res_n = {s2_q.sign, rnd[F] ? ex[E-1:0] : {E{1'b0}}, rnd[F-1:0]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (!stall) begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // datapath loads only behind a valid op so result holds between ops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
        end else if (!stall) begin
            if (in_valid) op_q <= '{a: a, b: b, sub: sub};
            if (v0) s1_q <= s1_n;
            if (v1) s2_q <= s2_n;
            if (v2) res_q <= res_n;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary32 configuration).
// Exact wide-integer reference model; monitor pops and compares.
module tb_fp_addsub_pipe;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    fp_addsub_pipe #(
        .EXP_BITS (8),
        .FRAC_BITS(23)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res   = '0;
    logic        rand_done  = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    // Exact value in units of 2^-149, rounded back to binary32.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic         sx, sy, sr;
        int           ex, ey, p, sh, e;
        logic [299:0] mx, my, m, rem, half, mant;
        sx = x[31];
        sy = y[31] ^ s;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return QNAN;
        if (ex == 255 && ey == 255) return (sx == sy) ? {sx, 8'hFF, 23'h0} : QNAN;
        if (ex == 255) return {sx, 8'hFF, 23'h0};
        if (ey == 255) return {sy, 8'hFF, 23'h0};
        mx = 300'({(ex != 0), x[22:0]});
        mx = mx << ((ex == 0) ? 0 : ex - 1);
        my = 300'({(ey != 0), y[22:0]});
        my = my << ((ey == 0) ? 0 : ey - 1);
        if (sx == sy) begin
            m = mx + my; sr = sx;
        end else if (mx >= my) begin
            m = mx - my; sr = sx;
        end else begin
            m = my - mx; sr = sy;
        end
        if (m == 0) return (sx == sy) ? {sx, 31'h0} : 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        sh   = (p > 23) ? p - 23 : 0;
        mant = m >> sh;
        if (sh > 0) begin
            rem  = m & ((300'(1) << sh) - 1);
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
            if (mant == (300'(1) << 24)) begin
                mant = mant >> 1;
                sh++;
            end
        end
        e = (mant >= (300'(1) << 23)) ? sh + 1 : 0;
        if (e >= 255) return {sr, 8'hFF, 23'h0};
        return {sr, 8'(e), mant[22:0]};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [31:0] ev);
        int   n;
        logic acc;
        a = x; b = y; sub = s; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else begin
            q.push_back(ev);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    // Monitor: scoreboard pop, stall stability and in_ready relation
    always @(negedge clock) begin
        logic [31:0] ev;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_result", result, prev_res);
            end
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got %h want none", result);
                end else begin
                    ev = q.pop_front();
                    chk("result", result, ev);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    logic [31:0] da[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001,
                            32'h7F800000, 32'h7F7FFFFF, 32'h7FC00001, 32'h00000001,
                            32'h00800000, 32'h80000000, 32'h00000000, 32'h3F800000};
    logic [31:0] db[12] = '{32'h3F800000, 32'h33800000, 32'h33800001, 32'h33800000,
                            32'hFF800000, 32'h7F7FFFFF, 32'h3F800000, 32'h00000001,
                            32'h00000001, 32'h80000000, 32'h80000000, 32'h7F800000};
    logic        ds[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] de[12] = '{32'h00000000, 32'h3F800000, 32'h3F800001, 32'h3F800002,
                            32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h00000002,
                            32'h007FFFFF, 32'h80000000, 32'h00000000, 32'hFF800000};

    task automatic rand_op(output logic [31:0] x, output logic [31:0] y, output logic s);
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: y[30:23] = x[30:23] ^ 8'($urandom_range(0, 3));
            2: begin x[30:25] = '0; y[30:25] = '0; end
            default: y = x ^ 32'($urandom_range(0, 15));
        endcase
        s = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] x, y;
        logic        s;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step();
        reset = 1'b0;

        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("latency_valid", 32'(out_valid), 32'(k == 3));
        end
        step();

        for (int i = 0; i < 12; i++) issue(da[i], db[i], ds[i], de[i]);
        drain();

        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    rand_op(x, y, s);
                    issue(x, y, s, ref_add(x, y, s));
                end
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (6) step();
                out_ready = 1'b1;
            end
        join
        drain();

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    rand_op(x, y, s);
                    issue(x, y, s, ref_add(x, y, s));
                    if ($urandom_range(0, 3) == 0) step();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        issue(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);
        issue(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000);
        step();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        repeat (2) step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("post_reset_idle", 32'(out_valid), 32'd0);
        end
        step();

        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_reset_latency", 32'(out_valid), 32'(k == 3));
        end
        step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
